// File: rtl/exception_controller.sv
// Kernel entry/exit sequencer: prioritises exceptions and interrupts, flushes
// the pipeline, then redirects to the handler or back to the saved EPC.
module exception_controller #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_irq,
  input  logic        syscallD,
  input  logic        illegalD,
  input  logic        eretD,
  input  logic        stall_pipe,
  input  logic [31:0] epc_in,
  output logic        cause_write,
  output logic [2:0]  int_cause,
  output logic        exit_kernel,
  output logic        flush_pipe,
  output logic        stall_fetch,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        double_fault
);

  typedef enum logic [1:0] {
    USER   = 2'd0,
    FLUSH  = 2'd1,
    ENTER  = 2'd2,
    KERNEL = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] cause, cause_n;
  logic       eret_q, eret_n;
  logic       irq_q, irq_pending;
  logic       irq_set, irq_clr;

  assign irq_set = ext_irq & ~irq_q;
  assign irq_clr = (state == ENTER) && (cause == 3'b001);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= KERNEL;
      cnt    <= '0;
      cause  <= '0;
      eret_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      cause  <= cause_n;
      eret_q <= eret_n;
    end
  end

  // Set has priority over the ENTER-cycle clear so no edge is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q       <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_q <= ext_irq;
      if (irq_set)
        irq_pending <= 1'b1;
      else if (irq_clr)
        irq_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      double_fault <= 1'b0;
    else if (state == KERNEL && (syscallD || illegalD))
      double_fault <= 1'b1;
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cause_n     = cause;
    eret_n      = 1'b0;
    cause_write = 1'b0;
    int_cause   = '0;
    exit_kernel = 1'b0;
    flush_pipe  = 1'b0;
    stall_fetch = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    case (state)
      USER: begin
        if (!stall_pipe && (illegalD || syscallD || irq_pending)) begin
          if (illegalD)      cause_n = 3'b011;
          else if (syscallD) cause_n = 3'b010;
          else               cause_n = 3'b001;
          cnt_n   = FLUSH_INIT;
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        flush_pipe  = 1'b1;
        stall_fetch = 1'b1;
        if (cnt <= 4'd1)
          state_n = ENTER;
        else
          cnt_n = cnt - 4'd1;
      end
      ENTER: begin
        cause_write = 1'b1;
        int_cause   = cause;
        pc_redirect = 1'b1;
        redirect_pc = HANDLER_ADDR;
        stall_fetch = 1'b1;
        state_n     = KERNEL;
      end
      KERNEL: begin
        // eret is registered so its strobes land one cycle after decode sees it.
        if (eret_q) begin
          exit_kernel = 1'b1;
          flush_pipe  = 1'b1;
          pc_redirect = 1'b1;
          redirect_pc = epc_in;
          state_n     = USER;
        end else if (eretD && !stall_pipe) begin
          eret_n = 1'b1;
        end
      end
      default: state_n = KERNEL;
    endcase
  end

endmodule

// File: tb/tb_exception_controller.sv
// Directed bench for exception_controller: per-cycle expected outputs are queued
// as stimulus is applied and compared when the cycle's outputs settle.
module tb_exception_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_irq, syscallD, illegalD, eretD, stall_pipe;
  logic [31:0] epc_in;
  logic        cause_write, exit_kernel, flush_pipe, stall_fetch, pc_redirect, double_fault;
  logic [2:0]  int_cause;
  logic [31:0] redirect_pc;

  exception_controller #(.HANDLER_ADDR(32'h0000_0100), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .ext_irq(ext_irq), .syscallD(syscallD),
    .illegalD(illegalD), .eretD(eretD), .stall_pipe(stall_pipe), .epc_in(epc_in),
    .cause_write(cause_write), .int_cause(int_cause), .exit_kernel(exit_kernel),
    .flush_pipe(flush_pipe), .stall_fetch(stall_fetch), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cw;
    logic [2:0]  ic;
    logic        ek;
    logic        fp;
    logic        sf;
    logic        pr;
    logic [31:0] rp;
    logic        df;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  logic df_exp = 1'b0;

  function automatic out_t mk(logic cw, logic [2:0] ic, logic ek, logic fp,
                              logic sf, logic pr, logic [31:0] rp);
    out_t o;
    o.cw = cw; o.ic = ic; o.ek = ek; o.fp = fp;
    o.sf = sf; o.pr = pr; o.rp = rp; o.df = df_exp;
    return o;
  endfunction

  function automatic out_t idle();   return mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); endfunction
  function automatic out_t fl();     return mk(1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0); endfunction
  function automatic out_t ent(logic [2:0] c); return mk(1'b1, c, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100); endfunction
  function automatic out_t eret(logic [31:0] e); return mk(1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, e); endfunction

  function automatic out_t observed();
    out_t o;
    o.cw = cause_write; o.ic = int_cause; o.ek = exit_kernel; o.fp = flush_pipe;
    o.sf = stall_fetch; o.pr = pc_redirect; o.rp = redirect_pc; o.df = double_fault;
    return o;
  endfunction

  // Called just after a rising edge with inputs for this cycle already applied.
  task automatic step(input out_t e, input string tag);
    out_t o, x;
    exp_q.push_back(e);
    @(negedge clk);
    o = observed();
    x = exp_q.pop_front();
    checks++;
    assert (o === x) passes++;
    else $error("FAIL %s: got %h expected %h", tag, o, x);
    @(posedge clk); #1;
  endtask

  task automatic chk_irq(input logic e, input string tag);
    checks++;
    assert (dut.irq_pending === e) passes++;
    else $error("FAIL %s: irq_pending got %b expected %b", tag, dut.irq_pending, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ext_irq = 1'b0; syscallD = 1'b0; illegalD = 1'b0;
    eretD = 1'b0; stall_pipe = 1'b0; epc_in = 32'h40;
    @(posedge clk); #1;
    step(idle(), "reset_0");
    chk_irq(1'b0, "reset_irq");
    step(idle(), "reset_1");
    reset = 1'b0;
    step(idle(), "kernel_idle");

    // Leave power-up kernel mode.
    eretD = 1'b1; step(idle(), "eret_sampled");
    eretD = 1'b0; step(eret(32'h40), "eret_strobe");
    step(idle(), "user_idle");

    // All three requests together: illegal wins, irq stays pending.
    illegalD = 1'b1; syscallD = 1'b1; ext_irq = 1'b1;
    step(idle(), "req_all");
    illegalD = 1'b0; syscallD = 1'b0;
    step(fl(), "flush_a1");
    step(fl(), "flush_a2");
    step(ent(3'b011), "enter_illegal");
    chk_irq(1'b1, "irq_kept");
    ext_irq = 1'b0;
    step(idle(), "kernel_a");

    // Return; pending irq is taken on the first user cycle.
    epc_in = 32'h200;
    eretD = 1'b1; step(idle(), "eret2_sampled");
    eretD = 1'b0; step(eret(32'h200), "eret2_strobe");
    step(idle(), "user_irq_sample");
    step(fl(), "flush_b1");
    step(fl(), "flush_b2");
    step(ent(3'b001), "enter_irq");
    chk_irq(1'b0, "irq_cleared");
    step(idle(), "kernel_b");

    // Syscall held off by stall, accepted on release.
    eretD = 1'b1; step(idle(), "eret3_sampled");
    eretD = 1'b0; step(eret(32'h200), "eret3_strobe");
    syscallD = 1'b1; stall_pipe = 1'b1;
    for (int i = 0; i < 4; i++) step(idle(), "stalled");
    stall_pipe = 1'b0;
    step(idle(), "stall_release");
    syscallD = 1'b0;
    step(fl(), "flush_c1");
    step(fl(), "flush_c2");
    step(ent(3'b010), "enter_syscall");
    step(idle(), "kernel_c");

    // Syscall inside kernel -> sticky double fault, no entry.
    syscallD = 1'b1; step(idle(), "kernel_syscall");
    syscallD = 1'b0; df_exp = 1'b1;
    step(idle(), "double_fault_1");
    step(idle(), "double_fault_2");
    step(idle(), "double_fault_3");

    // Reset in the middle of a flush.
    eretD = 1'b1; step(idle(), "eret4_sampled");
    eretD = 1'b0; step(eret(32'h200), "eret4_strobe");
    illegalD = 1'b1; ext_irq = 1'b1;
    step(idle(), "req_before_reset");
    illegalD = 1'b0;
    step(fl(), "flush_d1");
    chk_irq(1'b1, "irq_before_reset");
    #2;
    reset = 1'b1; ext_irq = 1'b0; df_exp = 1'b0;
    #1;
    begin
      out_t o;
      o = observed();
      checks++;
      assert (o === idle()) passes++;
      else $error("FAIL async_reset: got %h expected %h", o, idle());
    end
    chk_irq(1'b0, "irq_async_reset");
    @(posedge clk); #1;
    step(idle(), "reset_hold_no_enter");
    reset = 1'b0;
    step(idle(), "post_reset_idle");

    // Still in kernel after reset: syscall must flag double fault.
    syscallD = 1'b1; step(idle(), "post_reset_syscall");
    syscallD = 1'b0; df_exp = 1'b1;
    step(idle(), "post_reset_double_fault");
    step(idle(), "post_reset_no_entry");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
